// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select
// encoding and the layout of one buffered result entry.
package imm_pkg;

   localparam int IMM_SRC_W = 3;

   // Width used for the package-level entry type; each pipe instance
   // declares the same layout at its own XLEN.
   localparam int XLEN_DFLT = 32;

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM_I     = 3'd0,
      IMM_S     = 3'd1,
      IMM_B     = 3'd2,
      IMM_U     = 3'd3,
      IMM_J     = 3'd4,
      IMM_SHAMT = 3'd5
   } imm_src_t;

   // Field order matters: imm_ext occupies the MSBs, imm_err the LSB.
   typedef struct packed {
      logic [XLEN_DFLT-1:0] imm_ext;
      logic [XLEN_DFLT-1:0] pc_target;
      logic                 imm_err;
   } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side bus of the immediate generator.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The producer holds valid and its payload stable until that edge;
// ready may change freely and never depends combinationally on valid.
// The input side (in_valid/in_ready) carries instr/imm_src/pc, the output
// side (out_valid/out_ready) carries imm_ext/pc_target/imm_err.
interface imm_gen_pipe_if #(
   parameter int XLEN              = 32,
   parameter int INSTRUCTION_WIDTH = 32
) ();
   import imm_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic [INSTRUCTION_WIDTH-1:0] instr;
   logic [IMM_SRC_W-1:0]         imm_src;
   logic [XLEN-1:0]              pc;
   logic                         out_valid;
   logic                         out_ready;
   logic [XLEN-1:0]              imm_ext;
   logic [XLEN-1:0]              pc_target;
   logic                         imm_err;

   // Upstream/downstream environment side.
   modport master (
      output in_valid, instr, imm_src, pc, out_ready,
      input  in_ready, out_valid, imm_ext, pc_target, imm_err
   );

   // Immediate generator side.
   modport slave (
      input  in_valid, instr, imm_src, pc, out_ready,
      output in_ready, out_valid, imm_ext, pc_target, imm_err
   );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decode: extracts the selected immediate format,
// extends it to XLEN and forms the PC-relative target.
module imm_decode
   import imm_pkg::*;
#(
   parameter int  XLEN              = 32,
   parameter int  INSTRUCTION_WIDTH = 32,
   parameter type entry_t           = imm_entry_t
) (
   input  logic [INSTRUCTION_WIDTH-1:0] instr,
   input  logic [IMM_SRC_W-1:0]         imm_src,
   input  logic [XLEN-1:0]              pc,
   output entry_t                       entry
);

   logic [XLEN-1:0] imm;
   logic            err;
   logic [5:0]      shamt;
   logic            unused_opcode;

   // The opcode field never contributes to an immediate.
   assign unused_opcode = ^instr[6:0];

   // Format select; signed size casts do the sign extension to XLEN.
   always_comb begin
      imm   = '0;
      err   = 1'b0;
      // Bit 5 of the shift amount only exists on 64-bit datapaths.
      shamt = {(XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
      case (imm_src)
         IMM_I:     imm = XLEN'($signed(instr[31:20]));
         IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
         IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
         IMM_SHAMT: imm = XLEN'(shamt);
         default:   err = 1'b1;
      endcase
   end

   // Target adds a zero immediate for illegal formats, so it equals pc there.
   assign entry = {imm, pc + imm, err};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main/skid two-entry buffer so the
// decode stage can stall or flush without losing or repeating instructions.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN              = 32,
   parameter int INSTRUCTION_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] pc_target;
      logic            imm_err;
   } entry_t;

   entry_t dec_entry;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   in_xfer, out_xfer;

   imm_decode #(
      .XLEN              (XLEN),
      .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
      .entry_t           (entry_t)
   ) u_decode (
      .instr   (bus.instr),
      .imm_src (bus.imm_src),
      .pc      (bus.pc),
      .entry   (dec_entry)
   );

   assign in_xfer  = bus.in_valid && in_ready_q;
   assign out_xfer = main_valid_q && bus.out_ready;

   // Buffer update: drain main (refilling from skid), then place the new
   // entry in main when it is free this edge, otherwise in skid.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (out_xfer) begin
            if (skid_valid_q) begin
               main_d       = skid_q;
               skid_valid_d = 1'b0;
            end else begin
               main_valid_d = 1'b0;
            end
         end
         // in_xfer implies skid is empty, since in_ready mirrors !skid_valid.
         if (in_xfer) begin
            if (!main_valid_q || (out_xfer && !skid_valid_q)) begin
               main_d       = dec_entry;
               main_valid_d = 1'b1;
            end else begin
               skid_d       = dec_entry;
               skid_valid_d = 1'b1;
            end
         end
      end
      in_ready_d = !skid_valid_d;
   end

   // State registers; reset empties both slots and zeroes the output data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = main_valid_q;
   assign bus.imm_ext   = main_q.imm_ext;
   assign bus.pc_target = main_q.pc_target;
   assign bus.imm_err   = main_q.imm_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance with a scoreboard on its output
// stream, plus a 64-bit instance for the wide-format cases.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   localparam int W = 65;  // {imm_ext, pc_target, imm_err} at XLEN=32

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic        err;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic flush   = 1'b0;
   logic flush64 = 1'b0;
   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .INSTRUCTION_WIDTH(32)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64), .INSTRUCTION_WIDTH(32)) bus64 ();

   imm_gen_pipe #(.XLEN(32), .INSTRUCTION_WIDTH(32)) u_dut32 (
      .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus32)
   );
   imm_gen_pipe #(.XLEN(64), .INSTRUCTION_WIDTH(32)) u_dut64 (
      .clk (clk), .rst_n (rst_n), .flush (flush64), .bus (bus64)
   );

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] drv_exp;
   logic [W-1:0] mon_e;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Independent reference built from shifts and masks of the whole word.
   function automatic logic [W-1:0] model32(input logic [31:0] ins, input logic [2:0] src,
                                            input logic [31:0] pc);
      logic signed [31:0] s;
      logic [31:0] hi20, hi11, imm;
      logic        err;
      s    = ins;
      hi20 = s >>> 20;
      hi11 = s >>> 11;
      imm  = 32'h0;
      err  = 1'b0;
      case (src)
         3'd0: imm = hi20;
         3'd1: imm = (hi20 & ~32'h1F) | ((ins >> 7) & 32'h1F);
         3'd2: imm = (hi20 & 32'hFFFFF7E0) | ((ins >> 7) & 32'h1E) | ((ins << 4) & 32'h800);
         3'd3: imm = ins & 32'hFFFFF000;
         3'd4: imm = (hi11 & 32'hFFF00000) | (ins & 32'h000FF000) |
                     ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
         3'd5: imm = (ins >> 20) & 32'h1F;
         default: err = 1'b1;
      endcase
      return {imm, pc + imm, err};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus32.out_valid && bus32.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got imm=%h tgt=%h err=%b exp=none",
                        bus32.imm_ext, bus32.pc_target, bus32.imm_err);
            end else begin
               mon_e = exp_q.pop_front();
               if ({bus32.imm_ext, bus32.pc_target, bus32.imm_err} !== mon_e) begin
                  errors++;
                  $display("FAIL sb_out got imm=%h tgt=%h err=%b exp imm=%h tgt=%h err=%b",
                           bus32.imm_ext, bus32.pc_target, bus32.imm_err,
                           mon_e[64:33], mon_e[32:1], mon_e[0]);
               end
            end
         end
         if (flush) exp_q.delete();
         else if (bus32.in_valid && bus32.in_ready) exp_q.push_back(drv_exp);
      end
   end

   // ---------------- driver tasks ----------------
   // Present one instruction and hold it until accepted; returns 1 time unit
   // after the accepting edge.
   task automatic send32(input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] pc, input logic [W-1:0] e);
      int n;
      n = 0;
      bus32.instr    = ins;
      bus32.imm_src  = src;
      bus32.pc       = pc;
      drv_exp        = e;
      bus32.in_valid = 1'b1;
      @(negedge clk);
      while (!bus32.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus32.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready=0 exp=1");
      end
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic one64(input string name, input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] pc, input logic [63:0] imm,
                        input logic [63:0] tgt, input logic err);
      bus64.instr    = ins;
      bus64.imm_src  = src;
      bus64.pc       = pc;
      bus64.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus64.in_valid = 1'b0;
      chk({name, "_valid"}, 64'(bus64.out_valid), 64'd1);
      chk({name, "_imm"}, bus64.imm_ext, imm);
      chk({name, "_tgt"}, bus64.pc_target, tgt);
      chk({name, "_err"}, 64'(bus64.imm_err), 64'(err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bus32.in_valid = 1'b0; bus32.instr = '0; bus32.imm_src = '0; bus32.pc = '0;
      bus32.out_ready = 1'b1;
      bus64.in_valid = 1'b0; bus64.instr = '0; bus64.imm_src = '0; bus64.pc = '0;
      bus64.out_ready = 1'b1;
      drv_exp = '0;

      vecs[0] = '{32'hFFF00093, 3'd0, 32'h00000100, 32'hFFFFFFFF, 32'h000000FF, 1'b0};
      vecs[1] = '{32'hFE000EE3, 3'd2, 32'h00000200, 32'hFFFFFFFC, 32'h000001FC, 1'b0};
      vecs[2] = '{32'h800002A3, 3'd1, 32'h00001000, 32'hFFFFF805, 32'h00000805, 1'b0};
      vecs[3] = '{32'h7E000FA3, 3'd1, 32'h00000100, 32'h000007FF, 32'h000008FF, 1'b0};
      vecs[4] = '{32'h12345037, 3'd3, 32'h00000010, 32'h12345000, 32'h12345010, 1'b0};
      vecs[5] = '{32'h001000EF, 3'd4, 32'h00000020, 32'h00000800, 32'h00000820, 1'b0};
      vecs[6] = '{32'h8000006F, 3'd4, 32'h00100004, 32'hFFF00000, 32'h00000004, 1'b0};
      vecs[7] = '{32'h43F0D093, 3'd5, 32'h00000000, 32'h0000001F, 32'h0000001F, 1'b0};
      vecs[8] = '{32'hFFFFFFFF, 3'd6, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1};
      vecs[9] = '{32'h02000093, 3'd0, 32'hFFFFFFF0, 32'h00000020, 32'h00000010, 1'b0};

      // Reset state, sampled while reset is held.
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
      chk("rst_imm_ext", 64'(bus32.imm_ext), 64'd0);
      chk("rst_pc_target", 64'(bus32.pc_target), 64'd0);
      chk("rst_imm_err", 64'(bus32.imm_err), 64'd0);
      chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
      chk("rst64_out_valid", 64'(bus64.out_valid), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table: back-to-back vectors, one-cycle latency, full throughput.
      for (int i = 0; i < 10; i++) begin
         send32(vecs[i].instr, vecs[i].src, vecs[i].pc,
                {vecs[i].imm, vecs[i].tgt, vecs[i].err});
         chk($sformatf("vec%0d_valid", i), 64'(bus32.out_valid), 64'd1);
         chk($sformatf("vec%0d_imm", i), 64'(bus32.imm_ext), 64'(vecs[i].imm));
         chk($sformatf("vec%0d_tgt", i), 64'(bus32.pc_target), 64'(vecs[i].tgt));
      end
      wait_drain();

      // Backpressure: A, B fill the buffer, C waits until A drains.
      bus32.out_ready = 1'b0;
      send32(32'h00A00093, 3'd0, 32'h0, {32'hA, 32'hA, 1'b0});
      send32(32'h00B00093, 3'd0, 32'h0, {32'hB, 32'hB, 1'b0});
      chk("bp_in_ready_low", 64'(bus32.in_ready), 64'd0);
      bus32.instr = 32'h00C00093; bus32.imm_src = 3'd0; bus32.pc = 32'h0;
      drv_exp = {32'hC, 32'hC, 1'b0};
      bus32.in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("bp_stall_ready", 64'(bus32.in_ready), 64'd0);
         chk("bp_stall_hold", 64'(bus32.imm_ext), 64'hA);
      end
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_back", 64'(bus32.in_ready), 64'd1);
      chk("bp_out_b", 64'(bus32.imm_ext), 64'hB);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      chk("bp_valid_c", 64'(bus32.out_valid), 64'd1);
      chk("bp_out_c", 64'(bus32.imm_ext), 64'hC);
      @(posedge clk); #1;
      chk("bp_done", 64'(bus32.out_valid), 64'd0);
      wait_drain();

      // Flush with two entries buffered and a simultaneous input.
      bus32.out_ready = 1'b0;
      send32(32'h00D00093, 3'd0, 32'h0, {32'hD, 32'hD, 1'b0});
      send32(32'h00E00093, 3'd0, 32'h0, {32'hE, 32'hE, 1'b0});
      bus32.instr = 32'h00F00093; drv_exp = {32'hF, 32'hF, 1'b0};
      bus32.in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus32.in_valid = 1'b0;
      chk("flush2_out_valid", 64'(bus32.out_valid), 64'd0);
      chk("flush2_in_ready", 64'(bus32.in_ready), 64'd1);
      // Flush with one entry and an input that would otherwise be accepted.
      send32(32'h01000093, 3'd0, 32'h0, {32'h10, 32'h10, 1'b0});
      bus32.instr = 32'h01100093; drv_exp = {32'h11, 32'h11, 1'b0};
      bus32.in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      chk("flush1_out_valid", 64'(bus32.out_valid), 64'd0);
      @(posedge clk); #1;
      chk("flush1_lost", 64'(bus32.out_valid), 64'd0);
      // Illegal format right after the flush.
      send32(32'h00000013, 3'd7, 32'h40, {32'h0, 32'h40, 1'b1});
      chk("ill_imm", 64'(bus32.imm_ext), 64'd0);
      chk("ill_tgt", 64'(bus32.pc_target), 64'h40);
      chk("ill_err", 64'(bus32.imm_err), 64'd1);
      wait_drain();

      // Asynchronous reset between edges while an entry is presented.
      bus32.out_ready = 1'b0;
      send32(32'h7FF00093, 3'd0, 32'h0, {32'h7FF, 32'h7FF, 1'b0});
      chk("mrst_pre_valid", 64'(bus32.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(bus32.out_valid), 64'd0);
      chk("mrst_imm_ext", 64'(bus32.imm_ext), 64'd0);
      chk("mrst_pc_target", 64'(bus32.pc_target), 64'd0);
      chk("mrst_imm_err", 64'(bus32.imm_err), 64'd0);
      chk("mrst_in_ready", 64'(bus32.in_ready), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      bus32.out_ready = 1'b1;
      send32(32'h12300093, 3'd0, 32'h8, {32'h123, 32'h12B, 1'b0});
      chk("mrst_lat_valid", 64'(bus32.out_valid), 64'd1);
      chk("mrst_lat_tgt", 64'(bus32.pc_target), 64'h12B);
      wait_drain();

      // Random traffic with random backpressure and occasional flush.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ins, pc;
         logic [2:0]  src;
         ins = $urandom;
         pc  = $urandom;
         src = 3'($urandom_range(0, 7));
         bus32.instr = ins; bus32.imm_src = src; bus32.pc = pc;
         drv_exp = model32(ins, src, pc);
         bus32.in_valid  = 1'($urandom_range(0, 1));
         bus32.out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 40) == 0);
         @(posedge clk); #1;
      end
      bus32.in_valid = 1'b0; flush = 1'b0; bus32.out_ready = 1'b1;
      wait_drain();

      // 64-bit datapath formats.
      one64("x64_j", 32'h001000EF, 3'd4, 64'h0, 64'h800, 64'h800, 1'b0);
      one64("x64_u", 32'h80000037, 3'd3, 64'h1000,
            64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1'b0);
      one64("x64_shamt", 32'h43F0D093, 3'd5, 64'h0, 64'd63, 64'd63, 1'b0);
      one64("x64_i_wrap", 32'h02000093, 3'd0, 64'hFFFFFFFFFFFFFFF0, 64'h20, 64'h10, 1'b0);
      one64("x64_ill", 32'h00000013, 3'd7, 64'h40, 64'h0, 64'h40, 1'b1);
      @(posedge clk); #1;
      chk("x64_drained", 64'(bus64.out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
